// File: rtl/dram_rd_arb.sv
// Round-robin AXI4 read-address arbiter for feature/weight/bias fetchers, with a tag FIFO
// that steers returned R beats to the feature bus or the shared weight/bias bus.
module dram_rd_arb #(
   parameter int unsigned AXIWIDTH  = 128,
   parameter int unsigned LITEWIDTH = 32,
   parameter int unsigned LENWIDTH  = 8,
   parameter int unsigned OSTD      = 4
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   input  logic                 I_f_req,
   input  logic                 I_w_req,
   input  logic                 I_b_req,
   input  logic [LITEWIDTH-1:0] I_f_addr,
   input  logic [LITEWIDTH-1:0] I_w_addr,
   input  logic [LITEWIDTH-1:0] I_b_addr,
   input  logic [LENWIDTH-1:0]  I_f_len,
   input  logic [LENWIDTH-1:0]  I_w_len,
   input  logic [LENWIDTH-1:0]  I_b_len,
   output logic                 O_f_ack,
   output logic                 O_w_ack,
   output logic                 O_b_ack,
   output logic [LITEWIDTH-1:0] O_araddr,
   output logic [LENWIDTH-1:0]  O_arlen,
   output logic                 O_arvalid,
   input  logic                 I_arready,
   input  logic [AXIWIDTH-1:0]  I_rdata,
   input  logic                 I_rvalid,
   input  logic                 I_rlast,
   output logic                 O_rready,
   output logic [AXIWIDTH-1:0]  O_feature,
   output logic                 O_feature_dv,
   output logic [AXIWIDTH-1:0]  O_weight,
   output logic                 O_weight_dv,
   output logic                 O_weight_ch,
   output logic                 O_busy,
   output logic                 O_err
);

   localparam int unsigned PtrW = $clog2(OSTD);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StAddr, StAck} state_e;

   state_e                 state_q, state_d;
   logic [1:0]             last_q, last_d, win_q, win_d;
   logic [LITEWIDTH-1:0]   araddr_q, araddr_d;
   logic [LENWIDTH-1:0]    arlen_q, arlen_d;
   logic                   arvalid_q, arvalid_d;
   logic                   push;

   logic [1:0]             tag_id_q  [OSTD];
   logic [LENWIDTH-1:0]    tag_len_q [OSTD];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        cnt_q;

   logic [LENWIDTH-1:0]    bcnt_q, bcnt_d;
   logic                   err_q, err_d;
   logic [AXIWIDTH-1:0]    feat_q, wt_q;
   logic                   feat_dv_q, wt_dv_q, wt_ch_q;

   logic [2:0]             req;
   logic [1:0]             p0, p1, p2, pick_id;
   logic                   pick_vld;
   logic [LITEWIDTH-1:0]   sel_addr;
   logic [LENWIDTH-1:0]    sel_len;
   logic                   accept, pop;
   logic [1:0]             head_id;
   logic [LENWIDTH-1:0]    head_len;

   assign req = {I_b_req, I_w_req, I_f_req};

   // Search order rotates so the requester after the last grant goes first
   always_comb begin
      p0       = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      p1       = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
      p2       = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
      pick_vld = 1'b1;
      pick_id  = p0;
      if (req[p0])      pick_id = p0;
      else if (req[p1]) pick_id = p1;
      else if (req[p2]) pick_id = p2;
      else              pick_vld = 1'b0;
   end

   always_comb begin
      sel_addr = I_f_addr;
      sel_len  = I_f_len;
      case (pick_id)
         2'd1:    begin sel_addr = I_w_addr; sel_len = I_w_len; end
         2'd2:    begin sel_addr = I_b_addr; sel_len = I_b_len; end
         default: begin sel_addr = I_f_addr; sel_len = I_f_len; end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      win_d     = win_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arvalid_d = arvalid_q;
      push      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_vld && (cnt_q < CntW'(OSTD))) begin
               win_d     = pick_id;
               araddr_d  = sel_addr;
               arlen_d   = sel_len;
               arvalid_d = 1'b1;
               state_d   = StAddr;
            end
         end
         StAddr: begin
            if (I_arready) begin
               push      = 1'b1;
               last_d    = win_q;
               arvalid_d = 1'b0;
               state_d   = StAck;
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign O_rready = (cnt_q != '0);
   assign accept   = I_rvalid & O_rready;
   assign pop      = accept & I_rlast;
   assign head_id  = tag_id_q[rd_ptr_q];
   assign head_len = tag_len_q[rd_ptr_q];

   // Length mismatch in either direction is sticky; counting continues past len
   always_comb begin
      bcnt_d = bcnt_q;
      err_d  = err_q;
      if (accept) begin
         if (I_rlast) begin
            bcnt_d = '0;
            if (bcnt_q != head_len) err_d = 1'b1;
         end else begin
            bcnt_d = bcnt_q + LENWIDTH'(1);
            if (bcnt_q == head_len) err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (push) begin
         tag_id_q[wr_ptr_q]  <= win_q;
         tag_len_q[wr_ptr_q] <= arlen_q;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q   <= StIdle;
         last_q    <= 2'd2;
         win_q     <= 2'd0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arvalid_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         bcnt_q    <= '0;
         err_q     <= 1'b0;
         feat_q    <= '0;
         feat_dv_q <= 1'b0;
         wt_q      <= '0;
         wt_dv_q   <= 1'b0;
         wt_ch_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         win_q     <= win_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arvalid_q <= arvalid_d;
         bcnt_q    <= bcnt_d;
         err_q     <= err_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
         feat_dv_q <= accept && (head_id == 2'd0);
         wt_dv_q   <= accept && (head_id != 2'd0);
         if (accept && (head_id == 2'd0)) feat_q <= I_rdata;
         if (accept && (head_id != 2'd0)) begin
            wt_q    <= I_rdata;
            wt_ch_q <= (head_id == 2'd1);
         end
      end
   end

   assign O_f_ack      = (state_q == StAck) && (win_q == 2'd0);
   assign O_w_ack      = (state_q == StAck) && (win_q == 2'd1);
   assign O_b_ack      = (state_q == StAck) && (win_q == 2'd2);
   assign O_araddr     = araddr_q;
   assign O_arlen      = arlen_q;
   assign O_arvalid    = arvalid_q;
   assign O_feature    = feat_q;
   assign O_feature_dv = feat_dv_q;
   assign O_weight     = wt_q;
   assign O_weight_dv  = wt_dv_q;
   assign O_weight_ch  = wt_ch_q;
   assign O_busy       = (state_q != StIdle) || (cnt_q != '0);
   assign O_err        = err_q;

endmodule

// File: tb/tb_dram_rd_arb.sv
// Randomized bench for dram_rd_arb: a transaction-level model of grants, outstanding
// bursts and beat steering predicts every output each cycle.
module tb_dram_rd_arb;

   localparam int OS = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         f_req, w_req, b_req;
   logic [31:0]  f_addr, w_addr, b_addr;
   logic [7:0]   f_len, w_len, b_len;
   logic         f_ack, w_ack, b_ack;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic         arvalid, arready;
   logic [127:0] rdata;
   logic         rvalid, rlast, rready;
   logic [127:0] feature, weight;
   logic         feature_dv, weight_dv, weight_ch, busy, err;

   always #5 clk = ~clk;

   dram_rd_arb #(
      .AXIWIDTH (128),
      .LITEWIDTH(32),
      .LENWIDTH (8),
      .OSTD     (OS)
   ) u_dut (
      .I_clk       (clk),
      .I_rst       (rst),
      .I_f_req     (f_req),
      .I_w_req     (w_req),
      .I_b_req     (b_req),
      .I_f_addr    (f_addr),
      .I_w_addr    (w_addr),
      .I_b_addr    (b_addr),
      .I_f_len     (f_len),
      .I_w_len     (w_len),
      .I_b_len     (b_len),
      .O_f_ack     (f_ack),
      .O_w_ack     (w_ack),
      .O_b_ack     (b_ack),
      .O_araddr    (araddr),
      .O_arlen     (arlen),
      .O_arvalid   (arvalid),
      .I_arready   (arready),
      .I_rdata     (rdata),
      .I_rvalid    (rvalid),
      .I_rlast     (rlast),
      .O_rready    (rready),
      .O_feature   (feature),
      .O_feature_dv(feature_dv),
      .O_weight    (weight),
      .O_weight_dv (weight_dv),
      .O_weight_ch (weight_ch),
      .O_busy      (busy),
      .O_err       (err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: phase 0 = waiting to grant, 1 = address offered, 2 = acknowledging
   int           m_phase, m_win, m_last, m_bidx;
   logic [31:0]  m_addr;
   logic [7:0]   m_len;
   int           q_id[$];
   int           q_len[$];
   bit           m_fdv, m_wdv, m_wch, m_err;
   logic [127:0] m_fdata, m_wdata;
   bit           pend[3];
   logic [31:0]  raddr[3];
   logic [7:0]   rlen[3];
   int           p_req, p_ardy, p_rv;
   bit           inj_err, rec;
   int           gq[$];

   task automatic model_reset();
      m_phase = 0; m_win = 0; m_last = 2; m_bidx = 0;
      m_addr = '0; m_len = '0;
      q_id.delete(); q_len.delete();
      m_fdv = 0; m_wdv = 0; m_wch = 0; m_err = 0;
      m_fdata = '0; m_wdata = '0;
      for (int i = 0; i < 3; i++) pend[i] = 0;
   endtask

   task automatic drive_reqs();
      f_req = pend[0]; w_req = pend[1]; b_req = pend[2];
      f_addr = raddr[0]; w_addr = raddr[1]; b_addr = raddr[2];
      f_len = rlen[0]; w_len = rlen[1]; b_len = rlen[2];
   endtask

   task automatic check_outputs();
      logic [2:0] exp_ack;
      exp_ack = (m_phase == 2) ? 3'(1 << m_win) : 3'b000;
      check("arvalid", arvalid, m_phase == 1);
      if (m_phase == 1) begin
         check("araddr", araddr, m_addr);
         check("arlen", arlen, m_len);
      end
      check("acks", {b_ack, w_ack, f_ack}, exp_ack);
      check("rready", rready, q_id.size() != 0);
      check("feature_dv", feature_dv, m_fdv);
      if (m_fdv) check("feature", feature, m_fdata);
      check("weight_dv", weight_dv, m_wdv);
      if (m_wdv) begin
         check("weight", weight, m_wdata);
         check("weight_ch", weight_ch, m_wch);
      end
      check("busy", busy, (m_phase != 0) || (q_id.size() != 0));
      check("err", err, m_err);
   endtask

   task automatic drive_and_model();
      int sz0, head;
      bit ardy, rv, rl;
      logic [127:0] d;
      sz0 = q_id.size();
      for (int i = 0; i < 3; i++) begin
         if (m_phase == 2 && m_win == i) pend[i] = 0;
         if (m_phase == 1 && m_win == i) raddr[i] = $urandom();
         if (!pend[i] && ($urandom_range(0, 99) < p_req)) begin
            pend[i]  = 1;
            raddr[i] = $urandom();
            rlen[i]  = 8'($urandom_range(0, 3));
         end
      end
      drive_reqs();
      ardy = $urandom_range(0, 99) < p_ardy;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (sz0 != 0) begin
         rv = $urandom_range(0, 99) < p_rv;
         rl = inj_err ? ($urandom_range(0, 2) == 0) : (m_bidx == q_len[0]);
      end else begin
         rv = $urandom_range(0, 4) == 0;
         rl = $urandom_range(0, 1) == 1;
      end
      arready = ardy; rvalid = rv; rlast = rl; rdata = d;

      m_fdv = 0; m_wdv = 0;
      if (rv && sz0 != 0) begin
         head = q_id[0];
         if (head == 0) begin
            m_fdv = 1; m_fdata = d;
         end else begin
            m_wdv = 1; m_wdata = d; m_wch = (head == 1);
         end
         if (rl) begin
            if (m_bidx != q_len[0]) m_err = 1;
            void'(q_id.pop_front());
            void'(q_len.pop_front());
            m_bidx = 0;
         end else begin
            if (m_bidx == q_len[0]) m_err = 1;
            m_bidx = (m_bidx + 1) % 256;
         end
      end

      case (m_phase)
         0: if (sz0 < OS) begin
            for (int k = 1; k <= 3; k++) begin
               int id;
               id = (m_last + k) % 3;
               if (m_phase == 0 && pend[id]) begin
                  m_win = id; m_addr = raddr[id]; m_len = rlen[id]; m_phase = 1;
               end
            end
         end
         1: if (ardy) begin
            q_id.push_back(m_win);
            q_len.push_back(int'(m_len));
            m_last  = m_win;
            m_phase = 2;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic step(input bit do_rst);
      check_outputs();
      if (rec && (f_ack || w_ack || b_ack)) gq.push_back(f_ack ? 0 : (w_ack ? 1 : 2));
      if (do_rst) begin
         rst = 1;
         model_reset();
         drive_reqs();
         arready = 0; rvalid = 0; rlast = 0; rdata = '0;
      end else begin
         rst = 0;
         drive_and_model();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_arvalid"}, arvalid, 1'b0);
      check({tag, "_araddr"}, araddr, 32'd0);
      check({tag, "_arlen"}, arlen, 8'd0);
      check({tag, "_acks"}, {b_ack, w_ack, f_ack}, 3'b000);
      check({tag, "_rready"}, rready, 1'b0);
      check({tag, "_feature"}, feature, 128'd0);
      check({tag, "_weight"}, weight, 128'd0);
      check({tag, "_dv"}, {feature_dv, weight_dv, weight_ch}, 3'b000);
      check({tag, "_busy_err"}, {busy, err}, 2'b00);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         raddr[i] = '0; rlen[i] = '0;
      end
      model_reset();
      drive_reqs();
      rst = 1; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
      p_req = 0; p_ardy = 0; p_rv = 0; inj_err = 0; rec = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");

      // All three requesting continuously from reset
      p_req = 100; p_ardy = 100; p_rv = 100; rec = 1;
      for (int c = 0; c < 60; c++) step(0);
      rec = 0;
      check("grant_count", gq.size() >= 6, 1'b1);
      for (int i = 0; i < 6 && i < gq.size(); i++) check("grant_order", gq[i], i % 3);

      // No read data: outstanding limit stalls further grants, then drains
      p_rv = 0;
      for (int c = 0; c < 40; c++) step(0);
      check("ostd_full", q_id.size(), OS);
      p_rv = 100;
      for (int c = 0; c < 40; c++) step(0);

      // Mixed random traffic with a mid-run reset
      p_req = 30; p_ardy = 50; p_rv = 60;
      for (int c = 0; c < 1500; c++) step(c == 700);

      // Malformed bursts: sticky error, then reset clears everything
      inj_err = 1;
      for (int c = 0; c < 200; c++) step(0);
      check("err_sticky", err, 1'b1);
      inj_err = 0;
      step(1);
      check_reset_values("midrst");
      p_req = 40; p_ardy = 70; p_rv = 80;
      for (int c = 0; c < 300; c++) step(0);
      p_req = 0;
      for (int c = 0; c < 60; c++) step(0);
      check("drained_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_rd_arb.md
# dram_rd_arb

Read-channel arbiter that shares the accelerator's single AXI4 read master among three requesters: feature-line fetch, weight load and bias load. Grants address requests round-robin and tracks outstanding bursts in a tag FIFO. Steers returned beats to the feature input bus or to the shared weight/bias bus, with a channel select that drives the top-level weight/bias split. Sits between the DRAM read-address generators and the compute top.

## Interface
- AXIWIDTH, 128, AXI data width
- LITEWIDTH, 32, address width
- LENWIDTH, 8, AXI arlen width (beats-1 encoding)
- OSTD, 4, maximum outstanding bursts (power of two, 2..16)

Ports:
- I_clk  in  1  clock; all logic on rising edge
- I_rst  in  1  reset; synchronous, active-high
- I_f_req / I_w_req / I_b_req  in  1 each  feature / weight / bias request; held until the matching ack
- I_f_addr / I_w_addr / I_b_addr  in  LITEWIDTH each  burst byte address
- I_f_len / I_w_len / I_b_len  in  LENWIDTH each  burst length, beats-1
- O_f_ack / O_w_ack / O_b_ack  out  1 each  one-cycle grant-accepted pulse
- O_araddr  out  LITEWIDTH  AXI AR address
- O_arlen  out  LENWIDTH  AXI AR length
- O_arvalid  out  1  AXI AR valid
- I_arready  in  1  AXI AR ready
- I_rdata  in  AXIWIDTH  AXI R data
- I_rvalid  in  1  AXI R valid
- I_rlast  in  1  AXI R last
- O_rready  out  1  AXI R ready
- O_feature  out  AXIWIDTH  feature beat
- O_feature_dv  out  1  feature beat valid
- O_weight  out  AXIWIDTH  weight/bias beat
- O_weight_dv  out  1  weight/bias beat valid
- O_weight_ch  out  1  1 = weight beat, 0 = bias beat
- O_busy  out  1  state≠IDLE or bursts outstanding
- O_err  out  1  sticky protocol error

## Operation
- Requester IDs: F=0, W=1, B=2.
- AR FSM states: IDLE, ADDR, ACK.
- IDLE:
  - If any req is high and tag-FIFO count < OSTD, pick a winner round-robin.
  - Priority order starts at (last_grant+1) mod 3.
  - Latch the winner's addr/len into O_araddr/O_arlen, assert O_arvalid and go to ADDR.
- ADDR: hold O_arvalid, O_araddr and O_arlen stable until I_arready. On the handshake:
  - push {id, len} into the tag FIFO;
  - update last_grant;
  - drop O_arvalid and go to ACK.
- ACK: pulse the winner's O_x_ack for one cycle, then go to IDLE. Requesters deassert req, or present a new request, on the cycle after ack.
- Addr/len are latched at grant. Requesters may change them after grant.
- Round-robin pointer last_grant resets to B, so F has first priority after reset.
- O_rready = tag FIFO not empty. Downstream sinks have no backpressure.
- R beats (I_rvalid & O_rready) are steered by the FIFO head id:
  - F → O_feature / O_feature_dv.
  - W → O_weight / O_weight_dv with O_weight_ch=1.
  - B → O_weight / O_weight_dv with O_weight_ch=0.
- Beat counter for the head burst starts at 0 and increments per beat.
- On I_rlast: pop the head and clear the counter. If counter ≠ head len, set O_err.
- If the counter equals head len without I_rlast: set O_err and continue counting.
- I_rvalid while the FIFO is empty: O_rready=0, so nothing is accepted (no error).
- Tag FIFO push and pop in the same cycle leave the count unchanged. The full check is done only in IDLE, and between IDLE and the push only pops can occur, so the FIFO cannot overflow.
- Reset mid-operation:
  - FSM → IDLE; FIFO and counters cleared; O_arvalid dropped.
  - The AXI interconnect is reset on the same I_rst.

## Timing
- Reset values: O_arvalid=0, O_araddr=0, O_arlen=0, all acks 0, O_rready=0, O_feature=0, O_weight=0, all dv 0, O_weight_ch=0, O_busy=0, O_err=0.
- Grant latency, for req sampled in IDLE at cycle n:
  - O_arvalid high at n+1;
  - with I_arready=1, handshake at n+1, ack at n+2, IDLE at n+3.
  - Minimum 3 cycles per grant.
- Data path: beat accepted at cycle m → steered output and dv registered at m+1. Back-to-back beats give continuous dv.
- O_busy is combinational from state and FIFO count.

## Test plan
- Single feature request, addr 0x1000, len 3, arready=1:
  - arvalid at +1, O_f_ack at +2.
  - 4 R beats appear on O_feature with dv at each beat+1.
  - FIFO empty and O_busy=0 afterwards.
- F, W and B requesting simultaneously and continuously from reset: grant order F, W, B, F, W, B. Each ack is exactly one cycle.
- arready held low for 5 cycles in ADDR: arvalid, araddr and arlen stay stable. The ack comes on the cycle after arready rises.
- OSTD=4 with no R data returned:
  - 4 grants issued, the 5th request is stalled in IDLE.
  - After one rlast, the 5th grant issues within 2 cycles.
- Interleaved W (len 1) then B (len 0) bursts:
  - 2 beats with O_weight_ch=1, then 1 beat with O_weight_ch=0.
  - O_feature_dv stays 0.
- Burst len 3 with I_rlast on beat 2: O_err rises and stays set. The head is popped; the next burst steers correctly. I_rst mid-burst clears everything to reset values.
